// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch stage with IF/ID pipeline register.
// Ports: clk, rst_n, ID controls (wpcir, pcsource, bpc, rpc, jpc),
// imem handshake (imem_req/addr/rdata/ready), IF/ID outputs
// (dinst, dpc4, dvalid). Macro IF_FLUSH_EN: flush instead of delay slot.
`timescale 1ns/1ps
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] dinst,
  output logic [31:0] dpc4,
  output logic        dvalid
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] tgt;
  logic [31:0] npc;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc4;
  logic        redir;

`ifdef IF_FLUSH_EN
  logic        drop;
  logic [31:0] drop_addr;
`else
  logic        redir_pend;
  logic [31:0] redir_pc;
`endif

  assign pc4   = pc + 32'd4;
  assign redir = wpcir & (pcsource != 2'b00);

  always_comb begin
    tgt = pc4;
    unique case (1'b1)
      pcsource == 2'b00: tgt = pc4;
      pcsource == 2'b01: tgt = bpc;
      pcsource == 2'b10: tgt = rpc;
      pcsource == 2'b11: tgt = jpc;
    endcase
  end

  always_comb begin
    npc = pc4;
`ifndef IF_FLUSH_EN
    // Delay slot landing after an earlier redirect.
    if (pcsource != 2'b00)
      npc = tgt;
    else if (redir_pend)
      npc = redir_pc;
`endif
  end

  // Request drops the moment reset asserts.
  assign imem_req = rst_n & (state == FETCH);

`ifdef IF_FLUSH_EN
  // Keep the abandoned address on the bus until it answers.
  assign imem_addr = drop ? drop_addr : pc;
`else
  assign imem_addr = pc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      dinst    <= NOP_INST;
      dpc4     <= '0;
      dvalid   <= 1'b0;
      buf_inst <= NOP_INST;
      buf_pc4  <= '0;
`ifdef IF_FLUSH_EN
      drop      <= 1'b0;
      drop_addr <= RESET_PC;
`else
      redir_pend <= 1'b0;
      redir_pc   <= RESET_PC;
`endif
    end else begin
      unique case (state)
        FETCH: begin
`ifdef IF_FLUSH_EN
          if (drop) begin
            if (imem_ready)
              drop <= 1'b0;
          end else if (redir) begin
            dinst  <= NOP_INST;
            dvalid <= 1'b0;
            pc     <= tgt;
            if (!imem_ready) begin
              drop      <= 1'b1;
              drop_addr <= pc;
            end
          end else
`endif
          if (imem_ready && wpcir) begin
            dinst  <= imem_rdata;
            dpc4   <= pc4;
            dvalid <= 1'b1;
            pc     <= npc;
`ifndef IF_FLUSH_EN
            redir_pend <= 1'b0;
`endif
          end else if (imem_ready) begin
            buf_inst <= imem_rdata;
            buf_pc4  <= pc4;
            state    <= HOLD;
          end else if (wpcir) begin
            dinst  <= NOP_INST;
            dvalid <= 1'b0;
`ifndef IF_FLUSH_EN
            // Delay slot still in flight: park the target.
            if (redir) begin
              redir_pend <= 1'b1;
              redir_pc   <= tgt;
            end
`endif
          end
        end
        HOLD: begin
`ifdef IF_FLUSH_EN
          if (redir) begin
            dinst  <= NOP_INST;
            dvalid <= 1'b0;
            pc     <= tgt;
            state  <= FETCH;
          end else
`endif
          if (wpcir) begin
            dinst  <= buf_inst;
            dpc4   <= buf_pc4;
            dvalid <= 1'b1;
            pc     <= npc;
            state  <= FETCH;
`ifndef IF_FLUSH_EN
            redir_pend <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage.
// Memory returns {16'hC0DE, addr[15:0]} for each fetch.
`timescale 1ns/1ps
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] rpc;
  logic [31:0] jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] dinst;
  logic [31:0] dpc4;
  logic        dvalid;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wpcir      (wpcir),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dinst      (dinst),
    .dpc4       (dpc4),
    .dvalid     (dvalid)
  );

  function automatic logic [31:0] ins(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = ins(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wpcir = 1'b1;
    pcsource = 2'b00;
    bpc = '0;
    rpc = '0;
    jpc = '0;
    imem_ready = 1'b1;

    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_dinst", dinst, 0);
    chk("rst_dpc4", dpc4, 0);
    chk("rst_addr", imem_addr, 32'h3000);

    rst_n = 1'b1;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h3000);

    tick();
    chk("seq_dinst", dinst, ins(32'h3000));
    chk("seq_dpc4", dpc4, 32'h3004);
    chk("seq_dvalid", dvalid, 1);
    chk("seq_addr", imem_addr, 32'h3004);

    tick();
    chk("seq_dinst2", dinst, ins(32'h3004));
    chk("seq_addr2", imem_addr, 32'h3008);

    // stall while 0x3008 completes
    wpcir = 1'b0;
    tick();
    chk("hold_req", imem_req, 0);
    chk("hold_dinst", dinst, ins(32'h3004));
    chk("hold_dpc4", dpc4, 32'h3008);
    tick();
    chk("hold_req2", imem_req, 0);
    chk("hold_dinst2", dinst, ins(32'h3004));

    wpcir = 1'b1;
    tick();
    chk("resume_dinst", dinst, ins(32'h3008));
    chk("resume_dpc4", dpc4, 32'h300C);
    chk("resume_addr", imem_addr, 32'h300C);
    chk("resume_req", imem_req, 1);

    // no ready, stalled: all holds
    imem_ready = 1'b0;
    wpcir = 1'b0;
    tick();
    chk("idle_addr", imem_addr, 32'h300C);
    chk("idle_dinst", dinst, ins(32'h3008));
    chk("idle_dvalid", dvalid, 1);
    imem_ready = 1'b1;
    wpcir = 1'b1;

`ifndef IF_FLUSH_EN
    // beq taken, delay slot 0x300C completes at once
    pcsource = 2'b01;
    bpc = 32'h3100;
    tick();
    chk("br_slot_dinst", dinst, ins(32'h300C));
    chk("br_addr", imem_addr, 32'h3100);
    pcsource = 2'b00;
    tick();
    chk("br_tgt_dinst", dinst, ins(32'h3100));
    chk("br_tgt_addr", imem_addr, 32'h3104);

    // beq taken, delay slot 0x3104 slow for 3 cycles
    pcsource = 2'b01;
    bpc = 32'h3200;
    imem_ready = 1'b0;
    tick();
    chk("ds_bub_dvalid", dvalid, 0);
    chk("ds_bub_dinst", dinst, 0);
    chk("ds_addr", imem_addr, 32'h3104);
    pcsource = 2'b00;
    bpc = '0;
    tick();
    chk("ds_addr2", imem_addr, 32'h3104);
    chk("ds_dvalid2", dvalid, 0);
    tick();
    chk("ds_addr3", imem_addr, 32'h3104);
    imem_ready = 1'b1;
    tick();
    chk("ds_dinst", dinst, ins(32'h3104));
    chk("ds_dvalid", dvalid, 1);
    chk("ds_dpc4", dpc4, 32'h3108);
    chk("ds_tgt_addr", imem_addr, 32'h3200);

    // jr presented during a stall
    pcsource = 2'b10;
    rpc = 32'h3ABC;
    wpcir = 1'b0;
    tick();
    chk("jr_hold_req", imem_req, 0);
    chk("jr_hold_addr", imem_addr, 32'h3200);
    tick();
    chk("jr_hold_dinst", dinst, ins(32'h3104));
    rpc = 32'h3040;
    wpcir = 1'b1;
    tick();
    chk("jr_slot_dinst", dinst, ins(32'h3200));
    chk("jr_addr", imem_addr, 32'h3040);
    pcsource = 2'b00;
    tick();
    chk("jr_tgt_dinst", dinst, ins(32'h3040));
    chk("jr_tgt_addr", imem_addr, 32'h3044);

    // j/jal target
    pcsource = 2'b11;
    jpc = 32'h3300;
    tick();
    chk("j_dinst", dinst, ins(32'h3044));
    chk("j_addr", imem_addr, 32'h3300);

    // pc+4 wrap
    pcsource = 2'b10;
    rpc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    pcsource = 2'b00;
    tick();
    chk("wrap_dinst", dinst, ins(32'hFFFF_FFFC));
    chk("wrap_dpc4", dpc4, 0);
    chk("wrap_addr", imem_addr, 0);
`else
    // branch with fetch completing on the redirect edge
    pcsource = 2'b01;
    bpc = 32'h3100;
    tick();
    chk("fl_br_dvalid", dvalid, 0);
    chk("fl_br_dinst", dinst, 0);
    chk("fl_br_addr", imem_addr, 32'h3100);
    pcsource = 2'b00;
    tick();
    chk("fl_tgt_dinst", dinst, ins(32'h3100));
    chk("fl_tgt_dvalid", dvalid, 1);

    // j with 0x3104 outstanding
    pcsource = 2'b11;
    jpc = 32'h3200;
    imem_ready = 1'b0;
    tick();
    chk("fl_j_dvalid", dvalid, 0);
    chk("fl_j_addr", imem_addr, 32'h3104);
    chk("fl_j_req", imem_req, 1);
    pcsource = 2'b00;
    tick();
    chk("fl_wait_addr", imem_addr, 32'h3104);
    imem_ready = 1'b1;
    tick();
    chk("fl_drop_dvalid", dvalid, 0);
    chk("fl_drop_dinst", dinst, 0);
    chk("fl_drop_addr", imem_addr, 32'h3200);
    tick();
    chk("fl_new_dinst", dinst, ins(32'h3200));
    chk("fl_new_dvalid", dvalid, 1);

    // redirect out of HOLD discards buffer
    wpcir = 1'b0;
    tick();
    chk("fl_hold_req0", imem_req, 0);
    wpcir = 1'b1;
    pcsource = 2'b10;
    rpc = 32'h3040;
    tick();
    chk("fl_hold_dvalid", dvalid, 0);
    chk("fl_hold_addr", imem_addr, 32'h3040);
    chk("fl_hold_req", imem_req, 1);
    pcsource = 2'b00;
    tick();
    chk("fl_jr_dinst", dinst, ins(32'h3040));
`endif

    // reset in the middle of an outstanding request
    imem_ready = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_dvalid", dvalid, 0);
    chk("mid_rst_dinst", dinst, 0);
    chk("mid_rst_dpc4", dpc4, 0);
    chk("mid_rst_addr", imem_addr, 32'h3000);
    imem_ready = 1'b1;
    tick();
    chk("mid_rst_late", dvalid, 0);
    rst_n = 1'b1;
    #1;
    chk("refetch_req", imem_req, 1);
    chk("refetch_addr", imem_addr, 32'h3000);
    tick();
    chk("refetch_dinst", dinst, ins(32'h3000));
    chk("refetch_dpc4", dpc4, 32'h3004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline. Sits directly upstream of the ID control/decode stage.
- Holds the PC and fetches from a handshaked instruction memory. Selects the next PC from the ID stage's pcsource and targets.
- Honours the ID stall signal wpcir. Presents dinst/dpc4 to ID.
- Default behaviour is MIPS branch-delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word aligned.
- NOP_INST, 32'h0000_0000, bubble instruction inserted into IF/ID (ID decodes 0 as NOP).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wpcir  in  1  from ID; 1 = ID accepts/advances, 0 = load-use stall
- pcsource  in  2  from ID; 00 pc+4, 01 branch target, 10 jr register, 11 j/jal target
- bpc  in  32  branch target (ID)
- rpc  in  32  jr target (forwarded rs, ID)
- jpc  in  32  jump target {pc4[31:28],addr,2'b00} (ID)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; stable while imem_req=1 until imem_ready
- imem_rdata  in  32  fetched instruction, valid with imem_ready
- imem_ready  in  1  fetch complete this cycle
- dinst  out  32  IF/ID instruction
- dpc4  out  32  IF/ID pc+4
- dvalid  out  1  IF/ID holds a real (non-bubble) instruction

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, dinst=NOP_INST, dpc4=0, dvalid=0, redir_pend=0, imem_req=0.
- The first imem_req occurs on the first cycle after reset release.
- FSM states: FETCH, HOLD.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=1, wpcir=1: dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1, pc<=npc. Stay in FETCH.
  - imem_ready=1, wpcir=0: buf<=imem_rdata, bufpc4<=pc+4. IF/ID and pc unchanged. Go to HOLD.
  - imem_ready=0, wpcir=1: IF/ID<=bubble (NOP_INST, dvalid=0). pc unchanged.
  - imem_ready=0, wpcir=0: everything holds.
- HOLD: imem_req=0.
  - wpcir=1: IF/ID<=buf/bufpc4, dvalid<=1, pc<=npc. Go to FETCH.
  - wpcir=0: everything holds.
- pcsource/targets are sampled only on edges with wpcir=1; they are ignored while stalled.
- Target mux T: 00 -> pc+4, 01 -> bpc, 10 -> rpc, 11 -> jpc.
- npc = T when pcsource!=00; otherwise redir_pend ? redir_pc : pc+4.
- Redirect with the delay-slot fetch still outstanding (FETCH, imem_ready=0, wpcir=1, pcsource!=00):
  - redir_pend<=1, redir_pc<=T; ID receives a bubble.
  - When the delay slot later completes into IF/ID: pc<=redir_pc, redir_pend<=0.
- A redirect from ID while redir_pend=1 cannot occur, because ID holds a bubble.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32. No alignment checks.
- Reset mid-fetch: the request is abandoned immediately and any late imem_ready is ignored. Memory must tolerate a dropped request.
- Latency: instruction in IF/ID one edge after imem_ready, given wpcir=1.

Optional Feature:
- Macro IF_FLUSH_EN.
- Defined: no delay slot. On a taken redirect (wpcir=1, pcsource!=00):
  - IF/ID<=bubble; pc<=T.
  - If a fetch is outstanding (FETCH, imem_ready=0), set drop<=1. imem_addr stays stable. The next imem_ready response is discarded and no IF/ID write occurs; the next cycle fetches T.
  - In HOLD, buf is discarded and the FSM goes to FETCH at T.
  - A fetch completing on the redirect edge is discarded.
- Undefined: delay-slot semantics above; the drop logic is absent.

Test Plan:
- Reset release, imem_ready tied 1, wpcir=1, pcsource=00 -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; dpc4=0x3004 one edge after the first fetch; dvalid=1.
- wpcir=0 for 2 cycles while fetch of 0x3008 completes -> HOLD, imem_req=0, IF/ID unchanged. On wpcir=1, dinst=instr@0x3008, next imem_addr=0x300C.
- ID presents beq taken (pcsource=01, bpc=0x3100) while 0x3004 is fetched with ready=1 -> dinst=instr@0x3004 (delay slot), next imem_addr=0x3100.
- Same as above but imem_ready=0 for 3 cycles on 0x3004 -> ID receives bubbles (dvalid=0), imem_addr stays 0x3004. After completion, next imem_addr=0x3100.
- jr with rpc=0x3040 plus simultaneous wpcir=0 -> redirect ignored until wpcir=1, then the next fetch after the delay slot is at 0x3040.
- IF_FLUSH_EN: j to jpc=0x3200 with 0x3004 outstanding -> 0x3004 response dropped, dvalid=0, next imem_addr=0x3200.
- Any: assert rst_n=0 mid-request -> outputs at reset values immediately; refetch begins at 0x3000.
